// File: rtl/arbitro_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbitro_pkg : shared types and defaults for the two-requester mux arbiter |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
package arbitro_pkg;

  localparam int C_DATA_W   = 8;
  localparam int C_MAX_HOLD = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/contador_hold.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | contador_hold : saturating up-counter with clear, enable and at_max       |
// | Revision      : 1.0                                                       |
// +--------------------------------------------------------------------------+
module contador_hold #(
  parameter int MAX_VAL = 15,
  parameter int WIDTH   = (MAX_VAL < 1) ? 1 : $clog2(MAX_VAL + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic at_max
);

  logic [WIDTH-1:0] r_count;

  assign at_max = (r_count == WIDTH'(MAX_VAL));

  // Clear wins over enable so a grant edge always restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !at_max) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux2x1_mfd.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux2x1_mfd : single-bit 2:1 multiplexer                                   |
// | Revision   : 1.0                                                          |
// +--------------------------------------------------------------------------+
module mux2x1_mfd (
  input  logic i0,
  input  logic i1,
  input  logic S,
  output logic Y
);

  assign Y = S ? i1 : i0;

endmodule
`default_nettype wire

// File: rtl/arbitro_mux2x1.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arbitro_mux2x1 : round-robin arbiter owning a registered 2:1 data mux     |
// | Revision       : 1.0                                                      |
// +--------------------------------------------------------------------------+
module arbitro_mux2x1
  import arbitro_pkg::*;
#(
  parameter int DATA_W   = C_DATA_W,
  parameter int MAX_HOLD = C_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [1:0]        done,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  output logic [1:0]        gnt,
  output logic              S,
  output logic [DATA_W-1:0] Y,
  output logic              valid_out,
  output logic              busy
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_last;
  logic [1:0]        r_gnt;
  logic              r_s;
  logic [DATA_W-1:0] r_y;
  logic              r_valid;
  logic              r_busy;
  logic              w_grant;
  logic              w_owning;
  logic              w_at_max;
  logic [DATA_W-1:0] w_mux;

  assign w_owning = (r_state != IDLE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req == 2'b11) begin
          w_next = r_last ? OWN0 : OWN1;
        end else if (req[0]) begin
          w_next = OWN0;
        end else if (req[1]) begin
          w_next = OWN1;
        end
      end
      OWN0: begin
        if (done[0] || !req[0] || (w_at_max && req[1])) begin
          w_next = req[1] ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (done[1] || !req[1] || (w_at_max && req[0])) begin
          w_next = req[0] ? OWN0 : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // A grant is any edge that lands in an owner state different from today's.
  assign w_grant = (w_next != IDLE) && (w_next != r_state);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_gnt   <= 2'b00;
      r_s     <= 1'b0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gnt   <= {w_next == OWN1, w_next == OWN0};
      r_busy  <= (w_next != IDLE);
      if (w_grant) begin
        r_s    <= (w_next == OWN1);
        r_last <= (w_next == OWN1);
      end
      if (w_owning) begin
        r_y <= w_mux;
      end
      // On a hand-off Y still carries the previous owner's data, so not valid.
      r_valid <= w_owning && (w_next == r_state);
    end
  end

  contador_hold #(
    .MAX_VAL (MAX_HOLD)
  ) u_hold (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_grant),
    .enable (w_owning),
    .at_max (w_at_max)
  );

  generate
    for (genvar b = 0; b < DATA_W; b++) begin : g_mux
      mux2x1_mfd u_mux (
        .i0 (i0[b]),
        .i1 (i1[b]),
        .S  (r_s),
        .Y  (w_mux[b])
      );
    end
  endgenerate

  assign gnt       = r_gnt;
  assign S         = r_s;
  assign Y         = r_y;
  assign valid_out = r_valid;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/arbitro_mux2x1.md
ARBITRO_MUX2X1 -- requirements
Module: arbitro_mux2x1

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter DATA_W, default 8: width of each data input and of Y.
REQ-003 Parameter MAX_HOLD, default 15: maximum cycles one owner keeps the mux while the other requester waits.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  2  req[k] = requester k wants the shared mux.
REQ-007 done  input  2  done[k] = owner k releases the mux; ignored from a non-owner.
REQ-008 i0  input  DATA_W  data from requester 0.
REQ-009 i1  input  DATA_W  data from requester 1.
REQ-010 gnt  output  2  one-hot-or-zero grant, registered.
REQ-011 S  output  1  mux select, registered; equals the owner index.
REQ-012 Y  output  DATA_W  registered mux output.
REQ-013 valid_out  output  1  Y holds data sampled from the current owner.
REQ-014 busy  output  1  high while any grant is active.

Function
REQ-015 The FSM SHALL have three states: IDLE, OWN0 and OWN1; gnt = 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.
REQ-016 In IDLE with req != 0, the next state SHALL be OWN0 or OWN1; a single requester wins, and a tie goes to the requester not recorded in last_served.
REQ-017 Latency from a req assertion in IDLE to gnt high SHALL be exactly 1 clock.
REQ-018 On each grant, last_served SHALL be updated to the granted index and hold_cnt cleared to 0.
REQ-019 In OWNk, each clock SHALL load Y <= ik, and valid_out SHALL be 1 from the cycle after the grant edge.
REQ-020 In OWNk, hold_cnt SHALL increment by 1 per clock and saturate at MAX_HOLD; its width is $clog2(MAX_HOLD+1).
REQ-021 OWNk SHALL be exited when done[k]=1, or req[k]=0, or (hold_cnt==MAX_HOLD and req[other]=1).
- On exit with req[other]=1, the next state SHALL be OWNother, with no IDLE bubble.
- On exit otherwise, the next state SHALL be IDLE.
REQ-022 When done[k] and req[other] are asserted in the same cycle, ownership SHALL pass to the other requester on that edge.
REQ-023 If hold_cnt==MAX_HOLD with no other requester, the owner SHALL keep the mux indefinitely.
REQ-024 If req drops in the same cycle the grant is issued, the grant SHALL still last 1 cycle and then be released.
REQ-025 In IDLE, Y SHALL hold its last value, valid_out SHALL be 0 and busy SHALL be 0.
REQ-026 S SHALL change only on a grant edge, and SHALL keep its last value in IDLE.

Reset
REQ-027 While rst_n=0, the block SHALL force asynchronously: state=IDLE, gnt=0, S=0, Y=0, valid_out=0, busy=0, hold_cnt=0, last_served=1, so that requester 0 wins the first tie.
REQ-028 A reset asserted during OWNk SHALL drop gnt immediately, with no completion of the transfer.
REQ-029 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-030 Package arbitro_pkg SHALL hold the state enum (IDLE, OWN0, OWN1) and the DATA_W and MAX_HOLD defaults.
REQ-031 The datapath SHALL use DATA_W instances of the existing mux2x1_mfd (i0, i1, S, Y) in a generate loop, driven by registered S.
REQ-032 The only new sub-module SHALL be contador_hold: a saturating counter with clear, enable and at_max.

Verification
REQ-033 Reset: hold rst_n=0, drive req=2'b11 -> gnt=0, Y=0, valid_out=0; release rst_n, then 1 clock -> gnt=2'b01.
REQ-034 Single requester: req=2'b10, i1=8'hA5 -> gnt=2'b10 after 1 clock, S=1, Y=8'hA5 with valid_out=1 on the next clock.
REQ-035 Round robin: req=2'b11 held, done pulsed by each owner -> grants alternate 01, 10, 01, 10 with no IDLE cycle between them.
REQ-036 Starvation limit: MAX_HOLD=15, req[0] held without done, req[1] raised -> gnt switches to 2'b10 exactly 16 clocks after the OWN0 entry.
REQ-037 Reset mid-operation: rst_n pulled low during OWN1 with Y=8'h3C -> gnt, Y and valid_out go to 0 immediately, without waiting for clk.
REQ-038 Random: 7 iterations of random req, done, i0 and i1 -> a self-check each cycle that Y equals the owner's data from the prior cycle and gnt is never 2'b11.
